// File: rtl/motor_pkg.sv
// Shared types and constants for the motor PWM driver: gate FSM state encoding,
// period/duty widths and the slew-limited duty step helper.
package motor_pkg;

  localparam int unsigned DUTY_W = 8;
  localparam int unsigned DT_W   = 4;

  localparam logic [DUTY_W-1:0] PWM_MAX = 8'd254;

  typedef enum logic [2:0] {
    IDLE,
    DEAD_H,
    HIGH_ON,
    DEAD_L,
    LOW_ON
  } gate_state_t;

  // Move cur toward tgt by at most step; 9-bit math so neither direction wraps.
  function automatic logic [DUTY_W-1:0] slew_toward(
    input logic [DUTY_W-1:0] cur,
    input logic [DUTY_W-1:0] tgt,
    input logic [DUTY_W:0]   step
  );
    logic [DUTY_W:0] diff;
    logic [DUTY_W:0] res;
    if (tgt >= cur) begin
      diff = {1'b0, tgt} - {1'b0, cur};
      res  = {1'b0, cur} + ((diff < step) ? diff : step);
    end else begin
      diff = {1'b0, cur} - {1'b0, tgt};
      res  = {1'b0, cur} - ((diff < step) ? diff : step);
    end
    return res[DUTY_W-1:0];
  endfunction

endpackage

// File: rtl/deadtime_gate.sv
// Five-state complementary gate FSM with a dead-time down-counter; both gates
// are registered and can never be high together.
module deadtime_gate
  import motor_pkg::*;
#(
  parameter int unsigned DEADTIME = 2
) (
  input  logic c20k,
  input  logic reset,
  input  logic Enable,
  input  logic desired,
  output logic GateHigh,
  output logic GateLow
);

  localparam logic [DT_W-1:0] DT_LOAD = DT_W'(DEADTIME - 1);
  localparam logic [DT_W-1:0] DT_ONE  = DT_W'(1);

  gate_state_t     state;
  logic [DT_W-1:0] dt_cnt;

  always_ff @(posedge c20k or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      dt_cnt   <= '0;
      GateHigh <= 1'b0;
      GateLow  <= 1'b0;
    end else if (!Enable) begin
      state    <= IDLE;
      dt_cnt   <= '0;
      GateHigh <= 1'b0;
      GateLow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state    <= DEAD_L;
          dt_cnt   <= DT_LOAD;
          GateHigh <= 1'b0;
          GateLow  <= 1'b0;
        end
        LOW_ON: begin
          if (desired) begin
            state   <= DEAD_H;
            dt_cnt  <= DT_LOAD;
            GateLow <= 1'b0;
          end
        end
        HIGH_ON: begin
          if (!desired) begin
            state    <= DEAD_L;
            dt_cnt   <= DT_LOAD;
            GateHigh <= 1'b0;
          end
        end
        // Both dead states re-evaluate desired on exit, so a pulse that ended
        // during the dead interval falls straight back to the low side.
        DEAD_H, DEAD_L: begin
          if (dt_cnt != '0) begin
            dt_cnt <= dt_cnt - DT_ONE;
          end else if (desired) begin
            state    <= HIGH_ON;
            GateHigh <= 1'b1;
          end else begin
            state   <= LOW_ON;
            GateLow <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          dt_cnt   <= '0;
          GateHigh <= 1'b0;
          GateLow  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/motor_pwm_driver.sv
// Half-bridge PWM driver: 255-cycle period counter, period-synchronous slew-limited
// duty register and dead-time gate FSM. Optional ADC strobe: PWM_SAMPLE_TRIGGER_EN.
module motor_pwm_driver
  import motor_pkg::*;
#(
  parameter int unsigned DEADTIME  = 2,
  parameter int unsigned SLEW_STEP = 4
) (
  input  logic              c20k,
  input  logic              reset,
  input  logic [DUTY_W-1:0] MotorSignal,
  input  logic              Enable,
  output logic              GateHigh,
  output logic              GateLow,
  output logic [DUTY_W-1:0] AppliedDuty,
  output logic              PeriodStart,
  output logic              SampleTrigger
);

  localparam logic [DUTY_W:0]   STEP    = (DUTY_W + 1)'(SLEW_STEP);
  localparam logic [DUTY_W-1:0] CNT_ONE = DUTY_W'(1);

  logic [DUTY_W-1:0] cnt;
  logic              desired;

  always_ff @(posedge c20k or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      PeriodStart <= 1'b0;
    end else begin
      cnt         <= (cnt == PWM_MAX) ? '0 : cnt + CNT_ONE;
      PeriodStart <= (cnt == PWM_MAX);
    end
  end

  // MotorSignal is taken as the target in the count-254 cycle and applied on the
  // wrap edge; a disable clears the duty and overrides that boundary update.
  always_ff @(posedge c20k or posedge reset) begin
    if (reset) begin
      AppliedDuty <= '0;
    end else if (!Enable) begin
      AppliedDuty <= '0;
    end else if (cnt == PWM_MAX) begin
      AppliedDuty <= slew_toward(AppliedDuty, MotorSignal, STEP);
    end
  end

  always_comb begin
    desired = Enable && (cnt < AppliedDuty);
  end

  deadtime_gate #(
    .DEADTIME (DEADTIME)
  ) u_gate (
    .c20k     (c20k),
    .reset    (reset),
    .Enable   (Enable),
    .desired  (desired),
    .GateHigh (GateHigh),
    .GateLow  (GateLow)
  );

`ifdef PWM_SAMPLE_TRIGGER_EN
  always_ff @(posedge c20k or posedge reset) begin
    if (reset) begin
      SampleTrigger <= 1'b0;
    end else begin
      SampleTrigger <= Enable && (AppliedDuty >= 8'd2) && (cnt == (AppliedDuty >> 1));
    end
  end
`else
  assign SampleTrigger = 1'b0;
`endif

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Directed bench for motor_pwm_driver (DEADTIME=2, SLEW_STEP=4): per-period vector
// table plus hand sequences for power-up, disable, full ramp and async reset.
module tb_motor_pwm_driver;

`ifdef PWM_SAMPLE_TRIGGER_EN
  localparam bit TRIG = 1'b1;
`else
  localparam bit TRIG = 1'b0;
`endif

  logic       c20k = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] MotorSignal = 8'd0;
  logic       Enable = 1'b0;
  logic       GateHigh;
  logic       GateLow;
  logic [7:0] AppliedDuty;
  logic       PeriodStart;
  logic       SampleTrigger;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned overlaps = 0;

  motor_pwm_driver #(
    .DEADTIME  (2),
    .SLEW_STEP (4)
  ) dut (
    .c20k          (c20k),
    .reset         (reset),
    .MotorSignal   (MotorSignal),
    .Enable        (Enable),
    .GateHigh      (GateHigh),
    .GateLow       (GateLow),
    .AppliedDuty   (AppliedDuty),
    .PeriodStart   (PeriodStart),
    .SampleTrigger (SampleTrigger)
  );

  always #5 c20k = ~c20k;

  always @(negedge c20k) begin
    if (GateHigh && GateLow) overlaps++;
  end

  typedef struct {
    logic [7:0] ms;
    logic       en;
    int         duty;
    int         nh;
    int         nl;
    int         nt;
    int         tpos;
  } vec_t;

  function automatic vec_t mk(input logic [7:0] ms, input logic en, input int duty,
                              input int nh, input int nl, input int tpos);
    vec_t v;
    v.ms   = ms;
    v.en   = en;
    v.duty = duty;
    v.nh   = nh;
    v.nl   = nl;
    v.nt   = (TRIG && en && duty >= 2) ? 1 : 0;
    v.tpos = tpos;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge c20k);
    #1;
  endtask

  task automatic wait_boundary(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (PeriodStart) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Called on the sample right after a wrap edge; covers exactly one period.
  task automatic measure_period(output int nh, output int nl, output int nt,
                                output int tpos, output int nps);
    nh = 0; nl = 0; nt = 0; nps = 0; tpos = -1;
    for (int i = 0; i < 255; i++) begin
      if (i > 0) tick();
      nh  += int'(GateHigh);
      nl  += int'(GateLow);
      nt  += int'(SampleTrigger);
      nps += int'(PeriodStart);
      if (SampleTrigger && tpos < 0) tpos = i;
    end
  endtask

  vec_t vt[12];

  initial begin
    bit ok;
    int nh, nl, nt, tpos, nps;
    int k;
    int exp_d;

    vt[0]  = mk(8'd8,   1'b1, 4, 2, 249, 3);
    vt[1]  = mk(8'd8,   1'b1, 8, 6, 245, 5);
    vt[2]  = mk(8'd8,   1'b1, 8, 6, 245, 5);
    vt[3]  = mk(8'd6,   1'b1, 6, 4, 247, 4);
    vt[4]  = mk(8'd2,   1'b1, 2, 0, 253, 2);
    vt[5]  = mk(8'd1,   1'b1, 1, 0, 253, -1);
    vt[6]  = mk(8'd0,   1'b1, 0, 0, 255, -1);
    vt[7]  = mk(8'd200, 1'b1, 4, 2, 249, 3);
    vt[8]  = mk(8'd200, 1'b1, 8, 6, 245, 5);
    vt[9]  = mk(8'd200, 1'b0, 0, 0, 0,   -1);
    vt[10] = mk(8'd200, 1'b1, 4, 3, 248, 3);
    vt[11] = mk(8'd200, 1'b1, 8, 6, 245, 5);

    // Reset state, clock running
    Enable = 1'b1;
    MotorSignal = 8'd8;
    repeat (3) tick();
    check("rst_gate_high", GateHigh, 0);
    check("rst_gate_low", GateLow, 0);
    check("rst_duty", AppliedDuty, 0);
    check("rst_period_start", PeriodStart, 0);
    check("rst_sample_trig", SampleTrigger, 0);

    // GateLow rises DEADTIME+1 edges after release
    @(negedge c20k);
    reset = 1'b0;
    tick();
    check("low_rise_e1", GateLow, 0);
    tick();
    check("low_rise_e2", GateLow, 0);
    tick();
    check("low_rise_e3", GateLow, 1);

    // Inputs set in the count-254 cycle apply on the following wrap
    for (int i = 0; i < 12; i++) begin
      MotorSignal = vt[i].ms;
      Enable = vt[i].en;
      wait_boundary(ok);
      check($sformatf("v%0d_boundary", i), ok, 1);
      check($sformatf("v%0d_duty", i), AppliedDuty, vt[i].duty);
      measure_period(nh, nl, nt, tpos, nps);
      check($sformatf("v%0d_high_cycles", i), nh, vt[i].nh);
      check($sformatf("v%0d_low_cycles", i), nl, vt[i].nl);
      check($sformatf("v%0d_period_start", i), nps, 1);
      check($sformatf("v%0d_trig_count", i), nt, vt[i].nt);
      if (vt[i].nt != 0) check($sformatf("v%0d_trig_pos", i), tpos, vt[i].tpos);
    end

    // Disable while HIGH_ON at duty 8
    MotorSignal = 8'd8;
    wait_boundary(ok);
    check("dis_boundary", ok, 1);
    repeat (4) tick();
    check("dis_high_before", GateHigh, 1);
    Enable = 1'b0;
    tick();
    check("dis_high_after", GateHigh, 0);
    check("dis_low_after", GateLow, 0);
    check("dis_duty_after", AppliedDuty, 0);
    repeat (3) tick();
    Enable = 1'b1;
    MotorSignal = 8'd255;
    tick();
    check("reen_duty_mid", AppliedDuty, 0);

    // Soft-start ramp 0 -> 255
    for (k = 1; k <= 70; k++) begin
      wait_boundary(ok);
      check($sformatf("ramp%0d_boundary", k), ok, 1);
      exp_d = (k * 4 > 255) ? 255 : k * 4;
      check($sformatf("ramp%0d_duty", k), AppliedDuty, exp_d);
      if (AppliedDuty == 8'd100) begin
        measure_period(nh, nl, nt, tpos, nps);
        check("d100_high_cycles", nh, 98);
        check("d100_low_cycles", nl, 153);
        check("d100_trig_count", nt, TRIG ? 1 : 0);
`ifdef PWM_SAMPLE_TRIGGER_EN
        check("d100_trig_pos", tpos, 51);
`endif
      end
      if (AppliedDuty == 8'd255) break;
    end
    check("ramp_periods", k, 64);

    // Full duty: high across the wrap, low never asserted
    wait_boundary(ok);
    check("full_boundary", ok, 1);
    measure_period(nh, nl, nt, tpos, nps);
    check("full_high_cycles", nh, 255);
    check("full_low_cycles", nl, 0);
    tick();
    check("full_wrap_high", GateHigh, 1);
    check("full_wrap_ps", PeriodStart, 1);

    // Async reset between edges
    #2;
    reset = 1'b1;
    #1;
    check("async_gate_high", GateHigh, 0);
    check("async_gate_low", GateLow, 0);
    check("async_duty", AppliedDuty, 0);
    check("async_period_start", PeriodStart, 0);
    check("async_sample_trig", SampleTrigger, 0);
    @(negedge c20k);
    reset = 1'b0;
    tick();

    check("gate_overlap_cycles", overlaps, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/motor_pwm_driver.md
# motor_pwm_driver

Converts the 8-bit duty command produced by the current-control loop into a complementary half-bridge gate-drive pair with dead-time, period-synchronous duty updates and slew limiting. It is the consumer end of the `MotorSignal` interface: the control loop writes a duty word, and this block turns it into `GateHigh`/`GateLow` for the motor power stage. With the macro described under Configuration, it also emits a mid-pulse ADC sample strobe that feeds the phase-wire voltage measurement.

## Interface
- `DEADTIME`, default 2: both-gates-off interval in clock cycles, legal range 1..15.
- `SLEW_STEP`, default 4: maximum change of applied duty per PWM period, legal range 1..255.
- `c20k` input, 1 bit: sole clock. All logic is on the rising edge.
- `reset` input, 1 bit: asynchronous, active-high reset.
- `MotorSignal` input, 8 bits: commanded duty, unsigned. 0 = off, 255 = 100 %.
- `Enable` input, 1 bit: drive enable. Low forces both gates off.
- `GateHigh` output, 1 bit: high-side gate, registered.
- `GateLow` output, 1 bit: low-side gate, registered.
- `AppliedDuty` output, 8 bits: duty currently in effect.
- `PeriodStart` output, 1 bit: one-cycle pulse while the counter is 0.
- `SampleTrigger` output, 1 bit: one-cycle ADC strobe (see Configuration).

## Operation
- **Period counter**
  - 8-bit counter runs 0..254 and wraps to 0, giving a 255-cycle period.
  - It runs regardless of `Enable`.
- **Duty update**
  - In the cycle where the counter is 254, `MotorSignal` is sampled as the target.
  - On the next edge, together with the counter wrap to 0, `AppliedDuty` moves toward the target by min(`SLEW_STEP`, |target − AppliedDuty|).
  - The computation uses 9-bit arithmetic, so it never overflows or underflows.
  - `AppliedDuty` never changes mid-period.
- **Desired drive**
  - desired = `Enable` & (counter < `AppliedDuty`).
  - Duty 0 gives desired permanently 0.
  - Duty 255 gives desired permanently 1, because the counter never reaches 255.
- **Dead-time FSM states:** IDLE, DEAD_H, HIGH_ON, DEAD_L, LOW_ON.
  - IDLE: both gates 0. When `Enable` = 1, go to DEAD_L.
  - LOW_ON: `GateLow` = 1. If desired, go to DEAD_H.
  - DEAD_H: both gates 0 for exactly `DEADTIME` cycles. Then go to HIGH_ON if desired, else to LOW_ON.
  - HIGH_ON: `GateHigh` = 1. If not desired, go to DEAD_L.
  - DEAD_L: both gates 0 for exactly `DEADTIME` cycles. Then go to LOW_ON if not desired, else to HIGH_ON.
  - `Enable` = 0 in any state: go to IDLE on the next edge and clear `AppliedDuty` to 0, so that re-enable soft-starts through the slew limit.
- **Invariant:** `GateHigh` and `GateLow` are never both 1, in any cycle, under any stimulus.
- **Short pulses:** a duty ≤ `DEADTIME` produces no high-side pulse. The low side still opens for the dead interval.

## Timing
- **Reset values:** counter 0, FSM IDLE, `AppliedDuty` 0, `GateHigh` 0, `GateLow` 0, `PeriodStart` 0, `SampleTrigger` 0.
- **Reset assertion** clears everything asynchronously, including the gates, with no clock required.
- **After reset release with `Enable` = 1:** `GateLow` rises `DEADTIME`+1 cycles later.
- **Desired rising:**
  - `GateLow` falls 1 cycle later.
  - `GateHigh` rises `DEADTIME`+1 cycles later.
  - High pulse width is `AppliedDuty` − `DEADTIME` cycles.
- **Desired falling:**
  - `GateHigh` falls 1 cycle later.
  - `GateLow` rises `DEADTIME`+1 cycles later.
- **Command latency:** a `MotorSignal` change takes effect at the first period boundary after it is sampled at counter 254. Worst case is 255 cycles plus ramp time.
- **Full ramp:** 0→255 at `SLEW_STEP` = 4 takes 64 periods.
- **Simultaneous events:** if `Enable` falls in a boundary cycle, the clear to 0 wins over the slew update.

## Configuration
- Macro: `PWM_SAMPLE_TRIGGER_EN`.
- **Defined:** `SampleTrigger` pulses for one cycle when the counter equals `AppliedDuty` >> 1, which is the centre of the on-pulse. The pulse requires `AppliedDuty` ≥ 2 and `Enable` = 1; otherwise there is no pulse. The output is registered, so the pulse appears 1 cycle after that counter value.
- **Undefined:** `SampleTrigger` is tied to 0 and no compare logic is built.

## Structure
- **Package `motor_pkg`:**
  - gate FSM state enum;
  - `PWM_MAX` = 8'd254;
  - duty width constant (8);
  - `DEADTIME` width constant (4).
- **Sub-module `deadtime_gate`:** the five-state FSM plus the dead-time down-counter. Inputs are `c20k`, `reset`, `Enable`, desired; outputs are the two gates.
- **Top level:** period counter, duty shadow/slew register, and the sample trigger.

## Test plan
- Reset, `Enable` = 1, `MotorSignal` = 8, defaults → `AppliedDuty` reads 4, then 8 on successive boundaries. Each period at duty 8 shows `GateHigh` high for 6 cycles, with 2-cycle all-off gaps on both edges.
- `MotorSignal` = 255 → ramp in 64 periods. After the ramp, `GateHigh` stays continuously 1 across the wrap and `GateLow` stays 0.
- `AppliedDuty` = 2 with `DEADTIME` = 2 → `GateHigh` never asserts. `GateLow` drops for exactly 2 cycles per period.
- `Enable` drops while in HIGH_ON → both gates are 0 next cycle and `AppliedDuty` is 0. After re-enable, `AppliedDuty` ramps 0→4→8….
- Async `reset` pulse between clock edges while `GateHigh` = 1 → `GateHigh` is 0 before the next edge and all outputs are at reset values.
- With `PWM_SAMPLE_TRIGGER_EN` defined and `AppliedDuty` = 100 → one `SampleTrigger` pulse per period, 1 cycle after counter = 50. With duty 1, no pulse.
